// File: rtl/l1_dirty_flush_walker.sv
// l1_dirty_flush_walker
// Walks every set of the L1 dirty-bit file in ascending order and issues one
// writeback request per dirty way, lowest way first. Each dirty bit is cleared
// through the dirty file's write port in the same cycle its request is
// accepted, so the following rescan of the set sees the updated bits directly.
module l1_dirty_flush_walker #(
    parameter int SETS  = 8192,
    parameter int IDX_W = 13,
    parameter int WAYS  = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush_req,
    output logic             flush_busy,
    output logic             flush_done,
    output logic [IDX_W-1:0] dirty_ra,
    input  logic [WAYS-1:0]  dirty_rd,
    output logic [IDX_W-1:0] dirty_wa,
    output logic [WAYS-1:0]  dirty_way_hit,
    output logic             dirty_wr,
    output logic             dirty_in,
    output logic             wb_valid,
    input  logic             wb_ready,
    output logic [IDX_W-1:0] wb_set,
    output logic [1:0]       wb_way
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SCAN  = 2'd1,
        ISSUE = 2'd2,
        DONE  = 2'd3
    } state_t;

    // The last set index; the walk finishes here instead of wrapping to 0.
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(SETS - 1);

    state_t           state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [1:0]       way_q, way_d;
    logic             flush_busy_q, flush_busy_d;
    logic             flush_done_q, flush_done_d;
    logic             wb_valid_q, wb_valid_d;
    logic [1:0]       low_way;

    // Priority-encode the lowest dirty way of the set currently being read.
    always_comb begin
        low_way = 2'd0;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (dirty_rd[w]) begin
                low_way = 2'(w);
            end
        end
    end

    // Next-state logic for the walk, plus the status outputs decoded from the next state.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        way_d   = way_q;
        unique case (state_q)
            IDLE: begin
                if (flush_req) begin
                    idx_d   = '0;
                    state_d = SCAN;
                end
            end
            SCAN: begin
                if (dirty_rd == '0) begin
                    if (idx_q == LAST_IDX) begin
                        state_d = DONE;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end else begin
                    way_d   = low_way;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                if (wb_ready) begin
                    state_d = SCAN;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        flush_busy_d = (state_d != IDLE);
        flush_done_d = (state_d == DONE);
        wb_valid_d   = (state_d == ISSUE);
    end

    // Walker state and registered status outputs; reset returns to an idle, cleared walker.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            idx_q        <= '0;
            way_q        <= 2'd0;
            flush_busy_q <= 1'b0;
            flush_done_q <= 1'b0;
            wb_valid_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            way_q        <= way_d;
            flush_busy_q <= flush_busy_d;
            flush_done_q <= flush_done_d;
            wb_valid_q   <= wb_valid_d;
        end
    end

    // Drive the dirty-file ports and the writeback request; a reset in the handshake cycle suppresses the clear.
    always_comb begin
        flush_busy    = flush_busy_q;
        flush_done    = flush_done_q;
        wb_valid      = wb_valid_q;
        wb_set        = idx_q;
        wb_way        = way_q;
        dirty_ra      = idx_q;
        dirty_wa      = idx_q;
        dirty_in      = 1'b0;
        dirty_wr      = wb_valid_q && wb_ready && !reset;
        dirty_way_hit = dirty_wr ? (WAYS'(1) << way_q) : '0;
    end

endmodule

// File: tb/tb_l1_dirty_flush_walker.sv
// tb_l1_dirty_flush_walker
// Bench for the L1 dirty flush walker. A behavioural dirty-bit file answers
// reads and applies clears; the expected writeback list and flush duration are
// derived from the dirty-bit contents before each flush.
module tb_l1_dirty_flush_walker;

    localparam int SETS  = 8192;
    localparam int IDX_W = 13;
    localparam int WAYS  = 4;

    logic             clk = 1'b0;
    logic             reset;
    logic             flush_req;
    logic             flush_busy;
    logic             flush_done;
    logic [IDX_W-1:0] dirty_ra;
    logic [WAYS-1:0]  dirty_rd;
    logic [IDX_W-1:0] dirty_wa;
    logic [WAYS-1:0]  dirty_way_hit;
    logic             dirty_wr;
    logic             dirty_in;
    logic             wb_valid;
    logic             wb_ready;
    logic [IDX_W-1:0] wb_set;
    logic [1:0]       wb_way;

    logic [3:0] dirty_mem [SETS];

    int vectors     = 0;
    int miscompares = 0;

    typedef struct {
        int         set_a;
        logic [3:0] bits_a;
        int         set_b;
        logic [3:0] bits_b;
        int         exp_wbs;
        int         exp_cycles;
    } vec_t;

    vec_t vecs [4];

    l1_dirty_flush_walker #(.SETS(SETS), .IDX_W(IDX_W), .WAYS(WAYS)) dut (
        .clk           (clk),
        .reset         (reset),
        .flush_req     (flush_req),
        .flush_busy    (flush_busy),
        .flush_done    (flush_done),
        .dirty_ra      (dirty_ra),
        .dirty_rd      (dirty_rd),
        .dirty_wa      (dirty_wa),
        .dirty_way_hit (dirty_way_hit),
        .dirty_wr      (dirty_wr),
        .dirty_in      (dirty_in),
        .wb_valid      (wb_valid),
        .wb_ready      (wb_ready),
        .wb_set        (wb_set),
        .wb_way        (wb_way)
    );

    // Free-running clock, 10 time units per cycle.
    always #5 clk = ~clk;

    // Combinational read port of the dirty-bit file.
    assign dirty_rd = dirty_mem[dirty_ra];

    // Last-resort guard against a hung run.
    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: actual timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input int actual, input int expected);
        vectors++;
        if (actual != expected) begin
            miscompares++;
            $display("[TB] FAIL %s: actual %0d, expected %0d", name, actual, expected);
        end
    endtask

    // Drives the per-cycle inputs: ready policy and flush_req behaviour.
    task automatic applyStimulus(input int ready_mode, input bit toggle_req, input bit hold_req, input int stalls);
        case (ready_mode)
            0:       wb_ready = 1'b1;
            1:       wb_ready = ($urandom_range(0, 2) != 0);
            default: wb_ready = !(wb_valid && stalls < 10);
        endcase
        if (hold_req)        flush_req = 1'b1;
        else if (toggle_req) flush_req = 1'($urandom_range(0, 1));
        else                 flush_req = 1'b0;
    endtask

    task automatic clearMem();
        for (int s = 0; s < SETS; s++) dirty_mem[s] = 4'b0000;
    endtask

    // Presents flush_req for one edge while the walker is idle.
    task automatic startFlush();
        @(negedge clk);
        flush_req = 1'b1;
        wb_ready  = 1'b0;
    endtask

    // Follows one flush from its first SCAN cycle to its DONE cycle, checking every cycle.
    task automatic walk(input int ready_mode, input bit toggle_req, input bit hold_req,
                        output int busy_cycles, output int stall_cycles, output int valid_cycles);
        int         exp_set [$];
        int         exp_way [$];
        int         n;
        int         stalls = 0;
        int         valids = 0;
        int         hs = 0;
        int         cyc = 0;
        int         prev_ra = 0;
        int         dirty_left = 0;
        bit         reached_last = 0;
        bit         pend;
        int         pend_wa;
        logic [3:0] pend_hit;

        for (int s = 0; s < SETS; s++)
            for (int w = 0; w < WAYS; w++)
                if (dirty_mem[s][w]) begin
                    exp_set.push_back(s);
                    exp_way.push_back(w);
                end
        n = exp_set.size();

        for (int c = 1; c <= 4 * SETS; c++) begin
            @(negedge clk);
            applyStimulus(ready_mode, toggle_req, hold_req, stalls);
            #1;
            cyc = c;
            checkOutput("flush_busy", int'(flush_busy), 1);
            checkOutput("dirty_in", int'(dirty_in), 0);
            if (wb_valid) begin
                valids++;
                if (hs < n) begin
                    checkOutput("wb_set", int'(wb_set), exp_set[hs]);
                    checkOutput("wb_way", int'(wb_way), exp_way[hs]);
                    checkOutput("issue_ra", int'(dirty_ra), exp_set[hs]);
                end else begin
                    checkOutput("wb_count", hs + 1, n);
                end
            end
            if (wb_valid && wb_ready) begin
                checkOutput("dirty_wr_hs", int'(dirty_wr), 1);
                if (hs < n) begin
                    checkOutput("way_hit_hs", int'(dirty_way_hit), 1 << exp_way[hs]);
                    checkOutput("dirty_wa_hs", int'(dirty_wa), exp_set[hs]);
                end
                hs++;
            end else begin
                checkOutput("dirty_wr_idle", int'(dirty_wr), 0);
                checkOutput("way_hit_idle", int'(dirty_way_hit), 0);
                if (wb_valid) stalls++;
            end
            checkOutput("ra_order", int'(int'(dirty_ra) >= prev_ra), 1);
            prev_ra = int'(dirty_ra);
            if (reached_last) checkOutput("no_wrap", int'(dirty_ra), SETS - 1);
            if (int'(dirty_ra) == SETS - 1) reached_last = 1;
            checkOutput("flush_done", int'(flush_done), int'(cyc == SETS + 1 + 2 * n + stalls));
            pend     = dirty_wr;
            pend_wa  = int'(dirty_wa);
            pend_hit = dirty_way_hit;
            if (pend) begin
                @(posedge clk);
                #1;
                dirty_mem[pend_wa] = dirty_mem[pend_wa] & ~pend_hit;
            end
            if (flush_done || !flush_busy || cyc == SETS + 1 + 2 * n + stalls) break;
        end

        checkOutput("done_seen", int'(flush_done), 1);
        checkOutput("wb_total", hs, n);
        for (int s = 0; s < SETS; s++) if (dirty_mem[s] != 4'b0000) dirty_left++;
        checkOutput("sets_left_dirty", dirty_left, 0);
        busy_cycles  = cyc;
        stall_cycles = stalls;
        valid_cycles = valids;
    endtask

    // Confirms the walker has returned to idle with no further completion pulse.
    task automatic checkIdle(input string name);
        @(negedge clk);
        flush_req = 1'b0;
        wb_ready  = 1'b0;
        #1;
        checkOutput({name, "_busy"}, int'(flush_busy), 0);
        checkOutput({name, "_done"}, int'(flush_done), 0);
    endtask

    initial begin
        int busy;
        int stalls;
        int valids;
        int nset;

        vecs[0] = '{set_a: 0,    bits_a: 4'b0000, set_b: 0,    bits_b: 4'b0000, exp_wbs: 0, exp_cycles: 8193};
        vecs[1] = '{set_a: 5,    bits_a: 4'b1010, set_b: 0,    bits_b: 4'b0000, exp_wbs: 2, exp_cycles: 8197};
        vecs[2] = '{set_a: 8191, bits_a: 4'b1111, set_b: 0,    bits_b: 4'b0000, exp_wbs: 4, exp_cycles: 8201};
        vecs[3] = '{set_a: 0,    bits_a: 4'b0001, set_b: 4096, bits_b: 4'b0110, exp_wbs: 3, exp_cycles: 8199};

        reset     = 1'b1;
        flush_req = 1'b0;
        wb_ready  = 1'b0;
        clearMem();
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        checkOutput("rst_busy", int'(flush_busy), 0);
        checkOutput("rst_done", int'(flush_done), 0);
        checkOutput("rst_valid", int'(wb_valid), 0);
        checkOutput("rst_dirty_wr", int'(dirty_wr), 0);
        checkOutput("rst_way_hit", int'(dirty_way_hit), 0);
        checkOutput("rst_ra", int'(dirty_ra), 0);
        checkOutput("rst_wa", int'(dirty_wa), 0);
        checkOutput("rst_wb_set", int'(wb_set), 0);
        checkOutput("rst_wb_way", int'(wb_way), 0);

        // Directed flushes with wb_ready held high.
        for (int v = 0; v < 4; v++) begin
            clearMem();
            dirty_mem[vecs[v].set_a] = vecs[v].bits_a;
            dirty_mem[vecs[v].set_b] = dirty_mem[vecs[v].set_b] | vecs[v].bits_b;
            startFlush();
            walk(0, 1'b0, 1'b0, busy, stalls, valids);
            checkOutput("tbl_cycles", busy, vecs[v].exp_cycles);
            checkOutput("tbl_wbs", valids, vecs[v].exp_wbs);
            checkIdle("tbl_idle");
        end

        // Backpressure on set 0 with flush_req toggling throughout the flush.
        clearMem();
        dirty_mem[0] = 4'b0001;
        startFlush();
        walk(2, 1'b1, 1'b0, busy, stalls, valids);
        checkOutput("bp_stalls", stalls, 10);
        checkOutput("bp_valid_cycles", valids, 11);
        checkOutput("bp_cycles", busy, 8205);
        checkIdle("bp_idle");
        checkIdle("bp_idle2");

        // Random dirty map with random backpressure.
        clearMem();
        nset = 0;
        for (int i = 0; i < 24; i++) begin
            dirty_mem[$urandom_range(0, SETS - 1)] = 4'($urandom_range(1, 15));
        end
        if ($urandom_range(0, 1) == 1) dirty_mem[SETS - 1] = 4'($urandom_range(1, 15));
        for (int s = 0; s < SETS; s++)
            for (int w = 0; w < WAYS; w++)
                if (dirty_mem[s][w]) nset++;
        startFlush();
        walk(1, 1'b0, 1'b0, busy, stalls, valids);
        checkOutput("rnd_cycles", busy, SETS + 1 + 2 * nset + stalls);
        checkOutput("rnd_valid_cycles", valids, nset + stalls);
        checkIdle("rnd_idle");

        // Reset arriving in ISSUE while wb_ready is high.
        clearMem();
        dirty_mem[2] = 4'b0100;
        startFlush();
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            flush_req = 1'b0;
            wb_ready  = 1'b0;
            #1;
            if (wb_valid) break;
        end
        checkOutput("issue_reached", int'(wb_valid), 1);
        checkOutput("issue_set", int'(wb_set), 2);
        wb_ready = 1'b1;
        reset    = 1'b1;
        #1;
        checkOutput("rst_issue_dirty_wr", int'(dirty_wr), 0);
        checkOutput("rst_issue_way_hit", int'(dirty_way_hit), 0);
        @(negedge clk);
        reset    = 1'b0;
        wb_ready = 1'b0;
        #1;
        checkOutput("rst_issue_busy", int'(flush_busy), 0);
        checkOutput("rst_issue_valid", int'(wb_valid), 0);
        checkOutput("rst_issue_done", int'(flush_done), 0);
        for (int c = 0; c < 3; c++) checkIdle("rst_after");
        checkOutput("rst_issue_bits", int'(dirty_mem[2]), 4);

        // flush_req held high: a second flush follows after one IDLE cycle.
        clearMem();
        dirty_mem[7] = 4'b0011;
        startFlush();
        walk(0, 1'b0, 1'b1, busy, stalls, valids);
        checkOutput("hold1_cycles", busy, 8197);
        @(negedge clk);
        flush_req = 1'b1;
        #1;
        checkOutput("hold_gap_busy", int'(flush_busy), 0);
        checkOutput("hold_gap_done", int'(flush_done), 0);
        walk(0, 1'b0, 1'b1, busy, stalls, valids);
        checkOutput("hold2_cycles", busy, 8193);
        checkIdle("hold_end");
        checkIdle("hold_end2");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
